mem_port_arbiter: RTL and testbench

- Shares the single main-memory port between the fetch stage (read-only) and the memory stage (load/store).
- Sits between the two stage blocks and the main memory, and sequences one access at a time through a fixed-latency memory.
- Grants are data-priority, with a starvation guard that guarantees fetch forward progress.
- Completion is signalled by a one-cycle response pulse to the granted requester.

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port main-memory arbiter between fetch (read-only) and memory stage (load/store).
// One access in flight at a time; data has priority, bounded by a streak guard for fetch.
module mem_port_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int LATENCY         = 1,
   parameter int MAX_DATA_STREAK = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              fetch_gnt,
   output logic              fetch_rvalid,
   output logic [DATA_W-1:0] fetch_rdata,
   output logic              data_gnt,
   output logic              data_rvalid,
   output logic [DATA_W-1:0] data_rdata,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
   localparam int STK_W = (MAX_DATA_STREAK > 1) ? $clog2(MAX_DATA_STREAK + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY);
   localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_DATA_STREAK);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [STK_W-1:0]    streak_q, streak_d;
   logic                owner_fetch_q, owner_fetch_d;
   logic                fetch_gnt_q, fetch_gnt_d;
   logic                fetch_rvalid_q, fetch_rvalid_d;
   logic [DATA_W-1:0]   fetch_rdata_q, fetch_rdata_d;
   logic                data_gnt_q, data_gnt_d;
   logic                data_rvalid_q, data_rvalid_d;
   logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
   logic                busy_q, busy_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      streak_d       = streak_q;
      owner_fetch_d  = owner_fetch_q;
      fetch_gnt_d    = 1'b0;
      fetch_rvalid_d = 1'b0;
      fetch_rdata_d  = fetch_rdata_q;
      data_gnt_d     = 1'b0;
      data_rvalid_d  = 1'b0;
      data_rdata_d   = data_rdata_q;
      mem_en_d       = 1'b0;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;

      case (state_q)
         IDLE: begin
            if (fetch_req || data_req) begin
               // Fetch wins when alone, or when data has used up its streak allowance.
               if (fetch_req && (!data_req || (streak_q == STK_MAX))) begin
                  owner_fetch_d = 1'b1;
                  fetch_gnt_d   = 1'b1;
                  mem_addr_d    = fetch_addr;
                  mem_wdata_d   = '0;
                  mem_we_d      = 1'b0;
                  streak_d      = '0;
               end else begin
                  owner_fetch_d = 1'b0;
                  data_gnt_d    = 1'b1;
                  mem_addr_d    = data_addr;
                  mem_wdata_d   = data_wdata;
                  mem_we_d      = data_we;
                  if (!fetch_req) begin
                     streak_d = '0;
                  end else if (streak_q != STK_MAX) begin
                     streak_d = streak_q + 1'b1;
                  end
               end
               mem_en_d = 1'b1;
               cnt_d    = CNT_INIT;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               if (owner_fetch_q) begin
                  fetch_rvalid_d = 1'b1;
                  fetch_rdata_d  = mem_rdata;
               end else begin
                  data_rvalid_d = 1'b1;
                  data_rdata_d  = mem_we_q ? '0 : mem_rdata;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == WAIT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         streak_q       <= '0;
         owner_fetch_q  <= 1'b0;
         fetch_gnt_q    <= 1'b0;
         fetch_rvalid_q <= 1'b0;
         fetch_rdata_q  <= '0;
         data_gnt_q     <= 1'b0;
         data_rvalid_q  <= 1'b0;
         data_rdata_q   <= '0;
         busy_q         <= 1'b0;
         mem_en_q       <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         streak_q       <= streak_d;
         owner_fetch_q  <= owner_fetch_d;
         fetch_gnt_q    <= fetch_gnt_d;
         fetch_rvalid_q <= fetch_rvalid_d;
         fetch_rdata_q  <= fetch_rdata_d;
         data_gnt_q     <= data_gnt_d;
         data_rvalid_q  <= data_rvalid_d;
         data_rdata_q   <= data_rdata_d;
         busy_q         <= busy_d;
         mem_en_q       <= mem_en_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
      end
   end

   assign fetch_gnt    = fetch_gnt_q;
   assign fetch_rvalid = fetch_rvalid_q;
   assign fetch_rdata  = fetch_rdata_q;
   assign data_gnt     = data_gnt_q;
   assign data_rvalid  = data_rvalid_q;
   assign data_rdata   = data_rdata_q;
   assign busy         = busy_q;
   assign mem_en       = mem_en_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences, and a randomized
// run against a transaction-level reference model (LATENCY = 2, MAX_DATA_STREAK = 3).
module tb_mem_port_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int LAT  = 2;
   localparam int MAXS = 3;

   logic          clk, rst;
   logic          fetch_req, data_req, data_we;
   logic [AW-1:0] fetch_addr, data_addr;
   logic [DW-1:0] data_wdata;
   logic          fetch_gnt, fetch_rvalid, data_gnt, data_rvalid, busy, mem_en, mem_we;
   logic [DW-1:0] fetch_rdata, data_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .MAX_DATA_STREAK(MAXS)
   ) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
      .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
      .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
      .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a ^ 32'hDEADBEEF;
   endfunction

   // Fixed-latency memory: data for the mem_en cycle appears LAT cycles later, junk otherwise.
   logic          pipe_en   [LAT];
   logic [AW-1:0] pipe_addr [LAT];
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LAT; i++) begin
            pipe_en[i]   <= 1'b0;
            pipe_addr[i] <= '0;
         end
      end else begin
         pipe_en[0]   <= mem_en;
         pipe_addr[0] <= mem_addr;
         for (int i = 1; i < LAT; i++) begin
            pipe_en[i]   <= pipe_en[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
         end
      end
   end
   assign mem_rdata = pipe_en[LAT-1] ? mem_f(pipe_addr[LAT-1]) : 32'h0BAD0BAD;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   logic        e_fgnt, e_dgnt, e_frv, e_drv, e_men, e_mwe, e_busy;
   logic [31:0] e_frdata, e_drdata, e_maddr, e_mwdata;

   task automatic exp_zero();
      e_fgnt = 0; e_dgnt = 0; e_frv = 0; e_drv = 0; e_men = 0; e_mwe = 0; e_busy = 0;
      e_frdata = 0; e_drdata = 0; e_maddr = 0; e_mwdata = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".fetch_gnt"},    32'(fetch_gnt),    32'(e_fgnt));
      chk({tag, ".data_gnt"},     32'(data_gnt),     32'(e_dgnt));
      chk({tag, ".fetch_rvalid"}, 32'(fetch_rvalid), 32'(e_frv));
      chk({tag, ".data_rvalid"},  32'(data_rvalid),  32'(e_drv));
      chk({tag, ".mem_en"},       32'(mem_en),       32'(e_men));
      chk({tag, ".mem_we"},       32'(mem_we),       32'(e_mwe));
      chk({tag, ".busy"},         32'(busy),         32'(e_busy));
      chk({tag, ".fetch_rdata"},  fetch_rdata,       e_frdata);
      chk({tag, ".data_rdata"},   data_rdata,        e_drdata);
      chk({tag, ".mem_addr"},     mem_addr,          e_maddr);
      chk({tag, ".mem_wdata"},    mem_wdata,         e_mwdata);
   endtask

   typedef struct {
      logic        freq;
      logic [31:0] faddr;
      logic        dreq, dwe;
      logic [31:0] daddr, dwdata;
      logic        fgnt, dgnt, frv, drv, men, mwe, bsy;
      logic [31:0] frdata, drdata, maddr, mwdata;
   } vec_t;

   vec_t tbl [16];

   // Transaction-level model state (edge index based).
   int  m_now, m_arb_ok_at, m_rv_at, m_streak;
   bit  m_own_fetch;

   task automatic model_reset();
      exp_zero();
      m_now = 0; m_arb_ok_at = 0; m_rv_at = -1; m_streak = 0; m_own_fetch = 0;
   endtask

   task automatic model_step();
      bit fw;
      e_fgnt = 0; e_dgnt = 0; e_men = 0; e_frv = 0; e_drv = 0;
      if (m_now == m_rv_at) begin
         if (m_own_fetch) begin
            e_frv = 1; e_frdata = mem_f(e_maddr);
         end else begin
            e_drv = 1; e_drdata = e_mwe ? 32'h0 : mem_f(e_maddr);
         end
      end
      e_busy = (m_now < m_arb_ok_at - 1);
      if (m_now >= m_arb_ok_at && (fetch_req || data_req)) begin
         fw = fetch_req && (!data_req || m_streak == MAXS);
         if (fw) begin
            m_own_fetch = 1; e_fgnt = 1; e_maddr = fetch_addr; e_mwdata = 0; e_mwe = 0;
            m_streak = 0;
         end else begin
            m_own_fetch = 0; e_dgnt = 1; e_maddr = data_addr; e_mwdata = data_wdata;
            e_mwe = data_we;
            m_streak = fetch_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
         end
         e_men = 1; e_busy = 1;
         m_rv_at = m_now + LAT + 1;
         m_arb_ok_at = m_now + LAT + 2;
      end
      m_now++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit fpend, dpend;
      int got;
      int exp_order [5];

      tbl[0]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,  1, 0, 0, 0, 1, 0, 1, 32'h0,        32'h0,        32'h40,  32'h0};
      tbl[1]  = '{0, 32'h40, 0, 0, 32'h0,   32'h0,  0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h40,  32'h0};
      tbl[2]  = '{0, 32'h40, 0, 0, 32'h0,   32'h0,  0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h40,  32'h0};
      tbl[3]  = '{0, 32'h0,  0, 0, 32'h0,   32'h0,  0, 0, 1, 0, 0, 0, 0, 32'hDEADBEAF, 32'h0,        32'h40,  32'h0};
      tbl[4]  = '{0, 32'h0,  1, 0, 32'h100, 32'h77, 0, 1, 0, 0, 1, 0, 1, 32'hDEADBEAF, 32'h0,        32'h100, 32'h77};
      tbl[5]  = '{0, 32'h0,  0, 0, 32'h0,   32'h0,  0, 0, 0, 0, 0, 0, 1, 32'hDEADBEAF, 32'h0,        32'h100, 32'h77};
      tbl[6]  = '{0, 32'h0,  0, 0, 32'h0,   32'h0,  0, 0, 0, 0, 0, 0, 1, 32'hDEADBEAF, 32'h0,        32'h100, 32'h77};
      tbl[7]  = '{0, 32'h0,  0, 0, 32'h0,   32'h0,  0, 0, 0, 1, 0, 0, 0, 32'hDEADBEAF, 32'hDEADBFEF, 32'h100, 32'h77};
      tbl[8]  = '{1, 32'h44, 1, 1, 32'h8,   32'h55, 0, 1, 0, 0, 1, 1, 1, 32'hDEADBEAF, 32'hDEADBFEF, 32'h8,   32'h55};
      tbl[9]  = '{1, 32'h44, 0, 0, 32'h0,   32'h0,  0, 0, 0, 0, 0, 1, 1, 32'hDEADBEAF, 32'hDEADBFEF, 32'h8,   32'h55};
      tbl[10] = '{1, 32'h44, 0, 0, 32'h0,   32'h0,  0, 0, 0, 0, 0, 1, 1, 32'hDEADBEAF, 32'hDEADBFEF, 32'h8,   32'h55};
      tbl[11] = '{1, 32'h44, 0, 0, 32'h0,   32'h0,  0, 0, 0, 1, 0, 1, 0, 32'hDEADBEAF, 32'h0,        32'h8,   32'h55};
      tbl[12] = '{1, 32'h44, 0, 0, 32'h0,   32'h0,  1, 0, 0, 0, 1, 0, 1, 32'hDEADBEAF, 32'h0,        32'h44,  32'h0};
      tbl[13] = '{0, 32'h44, 0, 0, 32'h0,   32'h0,  0, 0, 0, 0, 0, 0, 1, 32'hDEADBEAF, 32'h0,        32'h44,  32'h0};
      tbl[14] = '{0, 32'h44, 0, 0, 32'h0,   32'h0,  0, 0, 0, 0, 0, 0, 1, 32'hDEADBEAF, 32'h0,        32'h44,  32'h0};
      tbl[15] = '{0, 32'h0,  0, 0, 32'h0,   32'h0,  0, 0, 1, 0, 0, 0, 0, 32'hDEADBEAB, 32'h0,        32'h44,  32'h0};

      rst = 0; fetch_req = 0; data_req = 0; data_we = 0;
      fetch_addr = 0; data_addr = 0; data_wdata = 0;
      #1;
      exp_zero();
      check_all("reset");
      @(negedge clk); rst = 1;

      for (int i = 0; i < 16; i++) begin
         fetch_req = tbl[i].freq; fetch_addr = tbl[i].faddr;
         data_req = tbl[i].dreq; data_we = tbl[i].dwe;
         data_addr = tbl[i].daddr; data_wdata = tbl[i].dwdata;
         @(posedge clk); #1;
         e_fgnt = tbl[i].fgnt; e_dgnt = tbl[i].dgnt; e_frv = tbl[i].frv; e_drv = tbl[i].drv;
         e_men = tbl[i].men; e_mwe = tbl[i].mwe; e_busy = tbl[i].bsy;
         e_frdata = tbl[i].frdata; e_drdata = tbl[i].drdata;
         e_maddr = tbl[i].maddr; e_mwdata = tbl[i].mwdata;
         check_all($sformatf("vec%0d", i));
      end

      // Reset during the mem_en cycle of a fetch: access must be abandoned.
      fetch_req = 1; fetch_addr = 32'h10; data_req = 0;
      @(posedge clk); #1;
      chk("rst_mid.mem_en_before", 32'(mem_en), 32'h1);
      fetch_req = 0;
      #2 rst = 0;
      #1 exp_zero();
      check_all("rst_mid");
      @(negedge clk); rst = 1;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         check_all($sformatf("idle%0d", i));
      end

      // Both requesters held high: three data grants, then fetch, then data.
      exp_order = '{0, 0, 0, 1, 0};
      fetch_req = 1; fetch_addr = 32'h200;
      data_req = 1; data_addr = 32'h300; data_we = 0; data_wdata = 32'h0;
      for (int g = 0; g < 5; g++) begin
         got = -1;
         for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (fetch_gnt || data_gnt) begin
               got = fetch_gnt ? 1 : 0;
               chk($sformatf("both.gnt%0d_onehot", g), 32'(fetch_gnt & data_gnt), 32'h0);
               chk($sformatf("both.gnt%0d_addr", g), mem_addr, fetch_gnt ? 32'h200 : 32'h300);
               break;
            end
         end
         chk($sformatf("both.grant%0d_owner", g), got, exp_order[g]);
      end
      fetch_req = 0; data_req = 0;
      for (int i = 0; i < LAT + 3; i++) @(posedge clk);

      // Randomized run against the reference model.
      @(negedge clk); rst = 0;
      @(negedge clk); rst = 1;
      model_reset();
      fpend = 0; dpend = 0;
      for (int c = 0; c < 2000; c++) begin
         if (fpend && e_fgnt) fpend = 0;
         if (dpend && e_dgnt) dpend = 0;
         if (!fpend) begin
            fetch_addr = $urandom;
            fpend = ($urandom_range(0, 3) != 0);
         end
         if (!dpend) begin
            data_addr  = $urandom;
            data_wdata = $urandom;
            data_we    = 1'($urandom_range(0, 1));
            dpend = ($urandom_range(0, 3) != 0);
         end
         fetch_req = fpend;
         data_req  = dpend;
         model_step();
         @(posedge clk); #1;
         check_all($sformatf("rnd%0d", c));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
